// File: rtl/soc_pkg.sv
// soc_pkg: shared FSM state enum and port ids for the memory arbiter
package soc_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic PORT_LOADER = 1'b0;
  localparam logic PORT_CPU = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: two-requester winner select; on contention the port not granted last wins
module arb_pick
  import soc_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o
);
  assign win_o = (req0_i && req1_i) ? ~last_i : (req1_i ? PORT_CPU : PORT_LOADER);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter onto a shared synchronous memory, fixed 3-cycle access
// define MEM_ARB_RR_EN for round-robin arbitration, otherwise m0 has fixed priority
module mem_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_ren,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  input  logic                m1_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_ren,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_ren,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                grant_id,
  output logic                busy
);
  state_e state_q, state_d;
  logic grant_q, grant_d, ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic last, win, latch, issue, resp;
  arb_pick u_pick (
    .req0_i(m0_req),
    .req1_i(m1_req),
    .last_i(last),
    .win_o (win)
  );
`ifdef MEM_ARB_RR_EN
  logic rr_q;
  always_ff @(posedge clk) rr_q <= rst ? PORT_CPU : (latch ? win : rr_q);
  assign last = rr_q;
`else
  assign last = PORT_CPU;
`endif
  assign latch = (state_q == IDLE) && (m0_req || m1_req);
  always_comb begin
    state_d = (state_q == ISSUE) ? RESP : (latch ? ISSUE : IDLE);
    grant_d = latch ? win : grant_q;
    addr_d  = latch ? (win ? m1_addr : m0_addr) : addr_q;
    ren_d   = latch ? (win ? m1_ren : m0_ren) : ren_q;
    wdata_d = latch ? (win ? m1_wdata : m0_wdata) : wdata_q;
    wmask_d = latch ? (win ? m1_wmask : m0_wmask) : wmask_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= PORT_LOADER;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end
  // strobes and acks are masked by rst so an aborted transaction never completes
  assign issue     = (state_q == ISSUE) && !rst;
  assign resp      = (state_q == RESP) && !rst;
  assign busy      = state_q != IDLE;
  assign grant_id  = grant_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ren   = issue && ren_q;
  assign mem_wmask = issue ? wmask_q : '0;
  assign m0_ack    = resp && (grant_q == PORT_LOADER);
  assign m1_ack    = resp && (grant_q == PORT_CPU);
  assign m0_rdata  = m0_ack ? mem_rdata : '0;
  assign m1_rdata  = m1_ack ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_req, m0_ren, m0_ack, m1_req, m1_ren, m1_ack, mem_ren, grant_id, busy;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] m0_wmask, m1_wmask, mem_wmask;
  logic [31:0] env_mem [16];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ren(m0_ren), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ren(m1_ren), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
  );

  // shared synchronous memory: 16 words, read data one cycle after mem_ren
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= '0;
    end else begin
      if (mem_ren) mem_rdata <= env_mem[mem_addr[5:2]];
      for (int b = 0; b < 4; b++) if (mem_wmask[b]) env_mem[mem_addr[5:2]][8*b+:8] <= mem_wdata[8*b+:8];
    end
  end

  task automatic set_req(input bit p, input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] m);
    if (p) begin m1_req = 1'b1; m1_addr = a; m1_ren = r; m1_wdata = d; m1_wmask = m; end
    else begin m0_req = 1'b1; m0_addr = a; m0_ren = r; m0_wdata = d; m0_wmask = m; end
  endtask

  task automatic clr_req(input bit p);
    if (p) m1_req = 1'b0;
    else m0_req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks got %b want 00", {m0_ack, m1_ack}); end
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ren got %0h want 0", mem_ren); end
    n_cmp++; if (mem_wmask !== 4'h0) begin n_bad++; $display("FAIL reset_wmask got %h want 0", mem_wmask); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL reset_grant got %0h want 0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_read;
    bit ok = 0;
    set_req(0, 32'h10, 1'b0, 32'hDEADBEEF, 4'hF);
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = m0_ack; end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL read_preload_ack got timeout want ack"); end
    clr_req(0);
    set_req(1, 32'h10, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL read_ren_cycN got %0h want 0", mem_ren); end
    @(negedge clk);
    n_cmp++; if (mem_ren !== 1'b1) begin n_bad++; $display("FAIL read_ren_cycN1 got %0h want 1", mem_ren); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL read_addr got %h want 10", mem_addr); end
    n_cmp++; if (grant_id !== 1'b1) begin n_bad++; $display("FAIL read_grant got %0h want 1", grant_id); end
    n_cmp++; if (m1_ack !== 1'b0) begin n_bad++; $display("FAIL read_early_ack got %0h want 0", m1_ack); end
    @(negedge clk);
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL read_ren_cycN2 got %0h want 0", mem_ren); end
    n_cmp++; if (m1_ack !== 1'b1) begin n_bad++; $display("FAIL read_ack got %0h want 1", m1_ack); end
    n_cmp++; if (m1_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata got %h want deadbeef", m1_rdata); end
    n_cmp++; if ({m0_ack, m0_rdata} !== 33'h0) begin n_bad++; $display("FAIL read_loser got %0h/%h want 0/0", m0_ack, m0_rdata); end
    clr_req(1);
    @(negedge clk);
    n_cmp++; if ({busy, m1_ack, m1_rdata} !== 34'h0) begin n_bad++; $display("FAIL read_after got %0h/%0h/%h want 0/0/0", busy, m1_ack, m1_rdata); end
  endtask

  task automatic test_write_read;
    int cnt = 0;
    bit ok = 0;
    logic [31:0] rd = '0;
    set_req(0, 32'h20, 1'b0, 32'h12345678, 4'hF);
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (m0_ack) begin cnt++; clr_req(0); end end
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL wr_ack_count got %0d want 1", cnt); end
    set_req(1, 32'h20, 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = m1_ack; rd = m1_rdata; end
    clr_req(1);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wr_read_ack got timeout want ack"); end
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL wr_read_data got %h want 12345678", rd); end
  endtask

  task automatic test_contention;
    bit seq [6];
    int at [6];
    int n = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 32'h0, 1'b1, 32'h0, 4'h0);
    set_req(1, 32'h4, 1'b1, 32'h0, 4'h0);
    for (int t = 0; t < 40 && n < 6; t++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        n_cmp++; if (m0_ack && m1_ack) begin n_bad++; $display("FAIL cont_double_ack got 11 want one-hot"); end
        seq[n] = m1_ack; at[n] = t; n++;
      end
    end
    clr_req(0);
    clr_req(1);
    n_cmp++; if (n != 6) begin n_bad++; $display("FAIL cont_count got %0d want 6", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (seq[i] !== (RR ? 1'(i % 2) : 1'b0)) begin n_bad++; $display("FAIL cont_grant%0d got m%0d want m%0d", i, seq[i], RR ? i % 2 : 0); end
      if (i > 0) begin n_cmp++; if (at[i] - at[i-1] != 3) begin n_bad++; $display("FAIL cont_spacing%0d got %0d want 3", i, at[i] - at[i-1]); end end
    end
  endtask

  task automatic test_reset_in_resp;
    bit ok = 0;
    set_req(1, 32'h10, 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 6 && !ok; i++) begin @(negedge clk); ok = mem_ren; end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rir_issue got timeout want mem_ren"); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr_req(1);
    @(negedge clk);
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_bad++; $display("FAIL rir_acks got %b want 00", {m0_ack, m1_ack}); end
    n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rir_rdata got %h want 0", m1_rdata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rir_busy got %0h want 0", busy); end
    n_cmp++; if (mem_ren !== 1'b0) begin n_bad++; $display("FAIL rir_mem_ren got %0h want 0", mem_ren); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("FAIL rir_grant got %0h want 0", grant_id); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rir_addr got %h want 0", mem_addr); end
  endtask

  task automatic test_req_drop;
    bit ok = 0;
    logic [31:0] rd = '0;
    set_req(1, 32'h24, 1'b1, 32'hA5A55A5A, 4'h5);
    for (int i = 0; i < 6 && !ok; i++) begin @(negedge clk); ok = busy; end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_latch got timeout want busy"); end
    m1_req = 1'b0; m1_addr = 32'h3C; m1_ren = 1'b0; m1_wdata = 32'hFFFFFFFF; m1_wmask = 4'hF;
    n_cmp++; if (mem_ren !== 1'b1) begin n_bad++; $display("FAIL drop_ren got %0h want 1", mem_ren); end
    n_cmp++; if (mem_wmask !== 4'h5) begin n_bad++; $display("FAIL drop_wmask got %h want 5", mem_wmask); end
    n_cmp++; if (mem_addr !== 32'h24) begin n_bad++; $display("FAIL drop_addr got %h want 24", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hA5A55A5A) begin n_bad++; $display("FAIL drop_wdata got %h want a5a55a5a", mem_wdata); end
    @(negedge clk);
    n_cmp++; if (m1_ack !== 1'b1) begin n_bad++; $display("FAIL drop_ack got %0h want 1", m1_ack); end
    n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++; $display("FAIL drop_rdata got %h want 0", m1_rdata); end
    @(negedge clk);
    n_cmp++; if ({busy, mem_ren, mem_wmask, m1_ack} !== 7'h0) begin n_bad++; $display("FAIL drop_idle got %0h/%0h/%h/%0h want 0/0/0/0", busy, mem_ren, mem_wmask, m1_ack); end
    n_cmp++; if (mem_addr !== 32'h24) begin n_bad++; $display("FAIL drop_addr_hold got %h want 24", mem_addr); end
    ok = 0;
    set_req(0, 32'h24, 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 8 && !ok; i++) begin @(negedge clk); ok = m0_ack; rd = m0_rdata; end
    clr_req(0);
    n_cmp++; if (!ok || rd !== 32'h00A5005A) begin n_bad++; $display("FAIL drop_readback got %0h/%h want 1/00a5005a", ok, rd); end
  endtask

  task automatic test_random;
    logic [31:0] refm [16];
    logic [31:0] fa [2];
    logic [31:0] fd [2];
    logic fr [2];
    logic [3:0] fm [2];
    bit pend [2];
    bit inflight = 0, wport = 0, last_win = 1, x_ren = 0;
    logic [31:0] x_addr = '0, x_wdata = '0, x_rd = '0;
    logic [3:0] x_mask = '0;
    int ack_cyc = 0, free_from = 0, nacks = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) refm[i] = '0;
    pend[0] = 0;
    pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      bit e0, e1, iss;
      e0 = inflight && c == ack_cyc && !wport;
      e1 = inflight && c == ack_cyc && wport;
      iss = inflight && c == ack_cyc - 1;
      n_cmp++; if (m0_ack !== e0) begin n_bad++; $display("FAIL rnd_m0_ack c%0d got %0h want %0h", c, m0_ack, e0); end
      n_cmp++; if (m1_ack !== e1) begin n_bad++; $display("FAIL rnd_m1_ack c%0d got %0h want %0h", c, m1_ack, e1); end
      n_cmp++; if (mem_ren !== (iss && x_ren)) begin n_bad++; $display("FAIL rnd_mem_ren c%0d got %0h want %0h", c, mem_ren, iss && x_ren); end
      n_cmp++; if (mem_wmask !== (iss ? x_mask : 4'h0)) begin n_bad++; $display("FAIL rnd_wmask c%0d got %h want %h", c, mem_wmask, iss ? x_mask : 4'h0); end
      if (!e0) begin n_cmp++; if (m0_rdata !== 32'h0) begin n_bad++; $display("FAIL rnd_m0_rdata_idle c%0d got %h want 0", c, m0_rdata); end end
      if (!e1) begin n_cmp++; if (m1_rdata !== 32'h0) begin n_bad++; $display("FAIL rnd_m1_rdata_idle c%0d got %h want 0", c, m1_rdata); end end
      if (iss) begin
        n_cmp++; if ({mem_addr, mem_wdata} !== {x_addr, x_wdata}) begin n_bad++; $display("FAIL rnd_issue c%0d got %h/%h want %h/%h", c, mem_addr, mem_wdata, x_addr, x_wdata); end
        set_req(wport, $urandom, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)));
      end
      if ((e0 || e1) && x_ren) begin
        n_cmp++; if ((wport ? m1_rdata : m0_rdata) !== x_rd) begin n_bad++; $display("FAIL rnd_rdata c%0d got %h want %h", c, wport ? m1_rdata : m0_rdata, x_rd); end
      end
      if (e0 || e1) begin inflight = 0; pend[wport] = 0; clr_req(wport); nacks++; free_from = c + 1; end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(2) == 0) begin
          pend[p] = 1;
          fa[p] = {26'h0, 4'($urandom_range(15)), 2'b00};
          fr[p] = 1'($urandom_range(1));
          fd[p] = $urandom;
          fm[p] = 4'($urandom_range(15));
          set_req(1'(p), fa[p], fr[p], fd[p], fm[p]);
        end
      end
      if (!inflight && c >= free_from && (pend[0] || pend[1])) begin
        wport = (pend[0] && pend[1]) ? (RR ? !last_win : 1'b0) : pend[1];
        last_win = wport;
        inflight = 1;
        ack_cyc = c + 2;
        x_addr = fa[wport]; x_ren = fr[wport]; x_wdata = fd[wport]; x_mask = fm[wport];
        x_rd = refm[x_addr[5:2]];
        for (int b = 0; b < 4; b++) if (x_mask[b]) refm[x_addr[5:2]][8*b+:8] = x_wdata[8*b+:8];
      end
      @(negedge clk);
    end
    clr_req(0);
    clr_req(1);
    repeat (4) @(negedge clk);
    n_cmp++; if (nacks < 50) begin n_bad++; $display("FAIL rnd_progress got %0d want >=50", nacks); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    m0_req = 0; m0_addr = '0; m0_ren = 0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 0; m1_addr = '0; m1_ren = 0; m1_wdata = '0; m1_wmask = '0;
    test_reset;
    test_read;
    test_write_read;
    test_contention;
    test_reset_in_resp;
    test_req_drop;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits; wmask width SHALL be DATA_W/8.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 m0_req / m1_req  input  1  access request; m0 = loader port, m1 = CPU port.
REQ-006 mN_addr  input  ADDR_W  byte address.
REQ-007 mN_ren  input  1  read strobe.
REQ-008 mN_wdata  input  DATA_W  write data.
REQ-009 mN_wmask  input  DATA_W/8  byte write enables.
REQ-010 mN_rdata  output  DATA_W  read data, valid while mN_ack=1.
REQ-011 mN_ack  output  1  one-cycle completion pulse.
REQ-012 mem_addr, mem_wdata, mem_wmask, mem_ren  output  widths as above  to the shared synchronous memory.
REQ-013 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_ren.
REQ-014 grant_id  output  1  port owning the current or last transaction.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-017 In IDLE with any req high, the arbiter SHALL select a winner, latch its addr/ren/wdata/wmask and grant_id, and move to ISSUE on the next edge.
REQ-018 In ISSUE, the arbiter SHALL drive the latched fields onto mem_* for exactly one cycle, then move to RESP.
REQ-019 In RESP, the arbiter SHALL pulse the winner's ack, drive its rdata from mem_rdata, and return to IDLE.
REQ-020 Latency SHALL be fixed: req sampled at edge N gives mem strobe in cycle N+1 and ack in cycle N+2; the port throughput limit is one access per 3 cycles.
REQ-021 Outside ISSUE, mem_ren SHALL be 0 and mem_wmask SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-022 The non-winning port's ack SHALL stay 0, and its rdata SHALL be 0 whenever its ack is 0.
REQ-023 A requester SHALL hold req and its fields stable until ack; the arbiter ignores field changes after the latch.
REQ-024 If req drops before ack, the latched access SHALL still complete and ack SHALL still pulse.
REQ-025 With ren=1 and wmask≠0 together, both SHALL pass through unchanged in the same ISSUE cycle.
REQ-026 A req present in the same cycle as another port's ack SHALL be considered in that same IDLE cycle; no extra idle cycle is inserted.
REQ-027 With both req low, the FSM SHALL remain in IDLE with all outputs at their idle values.

Reset
REQ-028 While rst=1 at an edge, the FSM SHALL enter IDLE, with all acks=0, mem_ren=0, mem_wmask=0, mem_addr=0, mem_wdata=0, grant_id=0, busy=0, and the round-robin pointer favouring m0.
REQ-029 Reset asserted in ISSUE or RESP SHALL abort the transaction without an ack; requesters re-present after reset.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: arbitration SHALL be round-robin; on contention the port that did not win last SHALL be granted.
REQ-031 MEM_ARB_RR_EN undefined: arbitration SHALL be fixed priority, with m0 always winning contention, and the round-robin pointer logic SHALL be absent.

Structure
REQ-032 Package soc_pkg SHALL hold the state enum (IDLE/ISSUE/RESP) and the port ID constants PORT_LOADER=0 and PORT_CPU=1.
REQ-033 Winner selection SHALL be the sub-module arb_pick (inputs: two reqs and last grant; output: winner id); the FSM stays in mem_arbiter.

Verification
REQ-034 The bench SHALL drive m1 read at 0x10 (memory holds 0xDEADBEEF): mem_ren is high exactly in cycle N+1, and m1_ack=1 with m1_rdata=0xDEADBEEF in cycle N+2.
REQ-035 The bench SHALL drive m0 write at 0x20 of 0x12345678 with wmask=0xF, then an m1 read at 0x20: the read returns 0x12345678, and m0_ack pulses once.
REQ-036 The bench SHALL hold both reqs continuously for 6 transactions: with RR_EN, grants alternate m0,m1,m0,m1,m0,m1; without RR_EN, all grants go to m0.
REQ-037 The bench SHALL assert rst during RESP: no ack fires, and the next cycle shows busy=0, mem_ren=0, grant_id=0.
REQ-038 The bench SHALL drop m1_req the cycle after it is latched: the access still completes, m1_ack pulses, and the next idle cycle has mem_wmask=0.
